// File: rtl/midi_parser.sv
// midi_parser: turns the MIDI UART receive byte stream into complete
// channel, system-common and realtime messages. Each message is packed into
// one 32-bit word and queued in a FIFO that the CPU reads through reg_q.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   din        received MIDI byte
//   din_valid  one-cycle strobe qualifying din
//   reg_re     one-cycle read strobe; pops the FIFO head
//   reg_q      {ovf, 5'b0, len, status, data1, data2}, or {ovf, 31'b0} when empty
//   empty      FIFO holds no messages
//   irq        level interrupt, equal to !empty
module midi_parser #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        reg_re,
    output logic [31:0] reg_q,
    output logic        empty,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {NONE, WAIT1, WAIT2, SYSEX} state_t;

    // Parser state
    state_t     state, state_n;
    logic [7:0] st, st_n;       // status byte of the message being assembled
    logic       need2, need2_n; // message takes two data bytes
    logic [7:0] d1, d1_n;       // first data byte, held while waiting for the second
    logic [7:0] rs, rs_n;       // running status byte
    logic       rs_vld, rs_vld_n;

    // Message completed this cycle: {len, status, data1, data2}
    logic        push;
    logic [25:0] push_word;

    // Cx and Dx carry one data byte; every other channel message carries two.
    function automatic logic chan_two(input logic [7:0] b);
        return b[6:5] != 2'b10;
    endfunction

    always_comb begin
        state_n   = state;
        st_n      = st;
        need2_n   = need2;
        d1_n      = d1;
        rs_n      = rs;
        rs_vld_n  = rs_vld;
        push      = 1'b0;
        push_word = '0;
        if (din_valid) begin
            if (din >= 8'hF8) begin
                // Realtime bytes interleave with anything, including sysex.
                push      = 1'b1;
                push_word = {2'd0, din, 16'h0000};
            end else if (din[7]) begin
                if (din < 8'hF0) begin
                    state_n  = WAIT1;
                    st_n     = din;
                    need2_n  = chan_two(din);
                    rs_n     = din;
                    rs_vld_n = 1'b1;
                end else begin
                    case (din)
                        8'hF0: begin
                            state_n  = SYSEX;
                            rs_vld_n = 1'b0;
                        end
                        8'hF1, 8'hF2, 8'hF3: begin
                            state_n  = WAIT1;
                            st_n     = din;
                            need2_n  = (din == 8'hF2);
                            rs_vld_n = 1'b0;
                        end
                        8'hF6: begin
                            state_n   = NONE;
                            rs_vld_n  = 1'b0;
                            push      = 1'b1;
                            push_word = {2'd0, din, 16'h0000};
                        end
                        8'hF7: begin
                            // Ends sysex; elsewhere it carries nothing but still
                            // abandons a partial message.
                            state_n = NONE;
                        end
                        default: begin // F4, F5
                            state_n  = NONE;
                            rs_vld_n = 1'b0;
                        end
                    endcase
                end
            end else begin
                case (state)
                    NONE: begin
                        // Running status: behave as if rs had just arrived.
                        if (rs_vld) begin
                            st_n    = rs;
                            need2_n = chan_two(rs);
                            if (chan_two(rs)) begin
                                d1_n    = din;
                                state_n = WAIT2;
                            end else begin
                                push      = 1'b1;
                                push_word = {2'd1, rs, din, 8'h00};
                            end
                        end
                    end
                    WAIT1: begin
                        if (need2) begin
                            d1_n    = din;
                            state_n = WAIT2;
                        end else begin
                            push      = 1'b1;
                            push_word = {2'd1, st, din, 8'h00};
                            state_n   = NONE;
                        end
                    end
                    WAIT2: begin
                        push      = 1'b1;
                        push_word = {2'd2, st, d1, din};
                        state_n   = NONE;
                    end
                    default: ; // SYSEX: payload discarded
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NONE;
            st     <= '0;
            need2  <= 1'b0;
            d1     <= '0;
            rs     <= '0;
            rs_vld <= 1'b0;
        end else begin
            state  <= state_n;
            st     <= st_n;
            need2  <= need2_n;
            d1     <= d1_n;
            rs     <= rs_n;
            rs_vld <= rs_vld_n;
        end
    end

    // FIFO
    logic [25:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          full, pop, wr;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign irq   = !empty;
    assign pop   = reg_re && !empty;
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr    = push && (!full || pop);

    assign reg_q = empty ? {ovf, 31'b0} : {ovf, 5'b0, mem[rd_ptr]};

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            // The read that observes ovf=1 is what clears it.
            if (reg_re)
                ovf <= 1'b0;
            else if (push && !wr)
                ovf <= 1'b1;
        end
    end
endmodule
